// File: rtl/tail_light_seq.sv
// Thunderbird-style tail-light sequencer: turn/hazard requests stepped at TICK_DIV-cycle intervals.
// Optional brake overlay enabled by defining TAIL_BRAKE_EN.
module tail_light_seq #(
  parameter int unsigned TICK_DIV = 12500000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       left,
  input  logic       right,
  input  logic       hazard,
`ifdef TAIL_BRAKE_EN
  input  logic       brake,
`endif
  output logic [5:0] lights_out,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle, StL1, StL2, StL3, StR1, StR2, StR3, StHz
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       lights_q, lights_d;
  logic             hz_req, any_req, tick;

  always_comb begin
    hz_req  = hazard | (left & right);
    any_req = hz_req | left | right;
    tick    = 1'b0;
    cnt_d   = cnt_q;
    state_d = state_q;

    // Idle without a request parks the prescaler so the first step is a full period away.
    if (state_q == StIdle && !any_req) begin
      cnt_d = '0;
    end else begin
      tick  = (cnt_q == CntMax);
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    if (tick) begin
      unique case (state_q)
        StIdle: begin
          if (hz_req)     state_d = StHz;
          else if (left)  state_d = StL1;
          else if (right) state_d = StR1;
        end
        StL1:    state_d = hz_req ? StHz : StL2;
        StL2:    state_d = hz_req ? StHz : StL3;
        StL3:    state_d = hz_req ? StHz : StIdle;
        StR1:    state_d = hz_req ? StHz : StR2;
        StR2:    state_d = hz_req ? StHz : StR3;
        StR3:    state_d = hz_req ? StHz : StIdle;
        StHz:    state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end

    lights_d = 6'b000000;
    unique case (state_d)
      StL1:    lights_d = 6'b001000;
      StL2:    lights_d = 6'b011000;
      StL3:    lights_d = 6'b111000;
      StR1:    lights_d = 6'b000100;
      StR2:    lights_d = 6'b000110;
      StR3:    lights_d = 6'b000111;
      StHz:    lights_d = 6'b111111;
      default: lights_d = 6'b000000;
    endcase

`ifdef TAIL_BRAKE_EN
    // Brake lights the half not used by the active turn; it never touches state or prescaler.
    if (brake) begin
      unique case (state_d)
        StIdle:               lights_d = 6'b111111;
        StL1, StL2, StL3:     lights_d = lights_d | 6'b000111;
        StR1, StR2, StR3:     lights_d = lights_d | 6'b111000;
        default:              lights_d = lights_d;
      endcase
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      lights_q <= 6'b000000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lights_q <= lights_d;
    end
  end

  assign lights_out = lights_q;
  assign busy       = (state_q != StIdle);

endmodule
